// File: rtl/spi_frame_decoder_pkg.sv
// Shared constants and types for the SPI frame decoder: command codes,
// field widths and the decoder state encoding.
package spi_frame_decoder_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_START = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   localparam int MAX_LEN_DEF     = 64;
   localparam int TIMEOUT_CYC_DEF = 4096;

   localparam int TILE_W = 3;
   localparam int OP_W   = 3;
   localparam int OFF_W  = 6;
   localparam int LEN_W  = 7;

   typedef enum logic [2:0] {IDLE, HDR_TILE, HDR_ARG, PAYLOAD, DRAIN} dec_state_t;

   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_WRITE) || (c == CMD_START) || (c == CMD_READ);
   endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Byte-stream input and decoded-action output bundle of the frame decoder.
// master = byte source / action consumer, slave = the decoder itself.
interface spi_frame_decoder_if;

   logic [7:0]                              rx_byte;
   logic                                    rx_valid;
   logic                                    cs_n;
   logic [7:0]                              cmd;
   logic [spi_frame_decoder_pkg::TILE_W-1:0] tile_i;
   logic [spi_frame_decoder_pkg::TILE_W-1:0] tile_j;
   logic [spi_frame_decoder_pkg::OP_W-1:0]   op_code;
   logic [7:0]                              data_in;
   logic [spi_frame_decoder_pkg::OFF_W-1:0]  offset;
   logic                                    valid;
   logic                                    start_pulse;
   logic                                    rd_req;
   logic                                    frame_err;
   logic                                    busy;

   modport master (
      output rx_byte, rx_valid, cs_n,
      input  cmd, tile_i, tile_j, op_code, data_in, offset,
             valid, start_pulse, rd_req, frame_err, busy
   );

   modport slave (
      input  rx_byte, rx_valid, cs_n,
      output cmd, tile_i, tile_j, op_code, data_in, offset,
             valid, start_pulse, rd_req, frame_err, busy
   );

endinterface

// File: rtl/spi_frame_decoder_timeout.sv
// Inter-byte stall counter: clears on demand, counts while enabled and
// holds at the expiry value so it can never wrap back into range.
module spi_frame_decoder_timeout #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses the received SPI byte stream into SRAM write bursts, tile start
// pulses and readback requests; bad or abandoned frames raise frame_err.
module spi_frame_decoder
   import spi_frame_decoder_pkg::*;
#(
   parameter int MAX_LEN     = MAX_LEN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   spi_frame_decoder_if.slave  bus
);

   dec_state_t              state_q;
   logic [7:0]              cmd_q;
   logic [TILE_W-1:0]       tile_i_q;
   logic [TILE_W-1:0]       tile_j_q;
   logic [OP_W-1:0]         op_q;
   logic [7:0]              data_q;
   logic [OFF_W-1:0]        off_q;
   logic [OFF_W-1:0]        idx_q;
   logic [LEN_W-1:0]        len_q;
   logic                    valid_q;
   logic                    start_q;
   logic                    rd_q;
   logic                    err_q;
   logic                    in_frame;
   logic                    tmo_expire;
   logic                    last_byte;

   assign in_frame  = (state_q == HDR_TILE) || (state_q == HDR_ARG) || (state_q == PAYLOAD);
   assign last_byte = ({1'b0, idx_q} == (len_q - 1'b1));

   spi_frame_decoder_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (bus.rx_valid || !in_frame),
      .count_en_i (in_frame),
      .expire_o   (tmo_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cmd_q    <= '0;
         tile_i_q <= '0;
         tile_j_q <= '0;
         op_q     <= '0;
         data_q   <= '0;
         off_q    <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         start_q <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.rx_valid && !bus.cs_n) begin
                  cmd_q <= bus.rx_byte;
                  if (cmd_known(bus.rx_byte)) begin
                     state_q <= HDR_TILE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= DRAIN;
                  end
               end
            end
            HDR_TILE, HDR_ARG, PAYLOAD: begin
               // A deasserted chip select aborts the frame even if a byte arrives with it.
               if (bus.cs_n) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (bus.rx_valid) begin
                  if (state_q == HDR_TILE) begin
                     if (bus.rx_byte[7:6] != 2'b00) begin
                        err_q   <= 1'b1;
                        state_q <= DRAIN;
                     end else begin
                        tile_i_q <= bus.rx_byte[5:3];
                        tile_j_q <= bus.rx_byte[2:0];
                        if (cmd_q == CMD_READ) begin
                           rd_q    <= 1'b1;
                           state_q <= IDLE;
                        end else begin
                           state_q <= HDR_ARG;
                        end
                     end
                  end else if (state_q == HDR_ARG) begin
                     if (cmd_q == CMD_WRITE) begin
                        if ((bus.rx_byte == 8'd0) || (bus.rx_byte > 8'(MAX_LEN))) begin
                           err_q   <= 1'b1;
                           state_q <= DRAIN;
                        end else begin
                           len_q   <= bus.rx_byte[LEN_W-1:0];
                           idx_q   <= '0;
                           state_q <= PAYLOAD;
                        end
                     end else begin
                        op_q    <= bus.rx_byte[OP_W-1:0];
                        start_q <= 1'b1;
                        state_q <= IDLE;
                     end
                  end else begin
                     data_q  <= bus.rx_byte;
                     off_q   <= idx_q;
                     valid_q <= 1'b1;
                     // Index stays put on the final byte, so it never wraps.
                     if (last_byte) begin
                        state_q <= IDLE;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end else if (tmo_expire) begin
                  err_q   <= 1'b1;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.cs_n) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cmd         = cmd_q;
   assign bus.tile_i      = tile_i_q;
   assign bus.tile_j      = tile_j_q;
   assign bus.op_code     = op_q;
   assign bus.data_in     = data_q;
   assign bus.offset      = off_q;
   assign bus.valid       = valid_q;
   assign bus.start_pulse = start_q;
   assign bus.rd_req      = rd_q;
   assign bus.frame_err   = err_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Table-driven bench for spi_frame_decoder: each step drives one cycle of input
// and queues the strobe it should cause; a negedge monitor pops and compares.
module tb_spi_frame_decoder;

   localparam int TIMEOUT_CYC = 4096;

   typedef enum logic [2:0] {EV_NONE, EV_VALID, EV_START, EV_RD, EV_ERR} ev_t;

   typedef struct {
      logic       v;
      logic       cs;
      logic [7:0] b;
      ev_t        ev;
      logic [5:0] off;
      logic [2:0] ti;
      logic [2:0] tj;
      logic [2:0] op;
      logic       busy;
   } step_t;

   typedef struct {
      ev_t        ev;
      logic [7:0] d;
      logic [5:0] off;
      logic [2:0] ti;
      logic [2:0] tj;
      logic [2:0] op;
      int         lo;
      int         hi;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   exp_t  exp_q[$];
   step_t tbl[$];

   spi_frame_decoder_if bus ();

   spi_frame_decoder #(
      .MAX_LEN     (64),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic step_t mk(logic v, logic cs, logic [7:0] b, ev_t ev, logic [5:0] off,
                                logic [2:0] ti, logic [2:0] tj, logic [2:0] op, logic busy);
      step_t s;
      s.v = v; s.cs = cs; s.b = b; s.ev = ev; s.off = off;
      s.ti = ti; s.tj = tj; s.op = op; s.busy = busy;
      return s;
   endfunction

   function automatic step_t sx(logic v, logic cs, logic [7:0] b, logic busy);
      return mk(v, cs, b, EV_NONE, 6'd0, 3'd0, 3'd0, 3'd0, busy);
   endfunction

   function automatic step_t sval(logic [7:0] b, logic [5:0] off, logic [2:0] ti, logic [2:0] tj, logic busy);
      return mk(1'b1, 1'b0, b, EV_VALID, off, ti, tj, 3'd0, busy);
   endfunction

   function automatic step_t sst(logic [7:0] b, logic [2:0] op, logic [2:0] ti, logic [2:0] tj);
      return mk(1'b1, 1'b0, b, EV_START, 6'd0, ti, tj, op, 1'b0);
   endfunction

   function automatic step_t srd(logic [7:0] b, logic [2:0] ti, logic [2:0] tj);
      return mk(1'b1, 1'b0, b, EV_RD, 6'd0, ti, tj, 3'd0, 1'b0);
   endfunction

   function automatic step_t serr(logic v, logic cs, logic [7:0] b, logic busy);
      return mk(v, cs, b, EV_ERR, 6'd0, 3'd0, 3'd0, 3'd0, busy);
   endfunction

   task automatic push_exp(input ev_t ev, input logic [7:0] d, input logic [5:0] off, input logic [2:0] ti,
                           input logic [2:0] tj, input logic [2:0] op, input int lo, input int hi);
      exp_t e;
      e.ev = ev; e.d = d; e.off = off; e.ti = ti; e.tj = tj; e.op = op; e.lo = lo; e.hi = hi;
      exp_q.push_back(e);
   endtask

   task automatic apply(input step_t s);
      @(negedge clk);
      bus.rx_valid = s.v;
      bus.cs_n     = s.cs;
      bus.rx_byte  = s.b;
      if (s.ev != EV_NONE) push_exp(s.ev, s.b, s.off, s.ti, s.tj, s.op, cyc + 1, cyc + 1);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== s.busy) begin
         n_bad++;
         $display("FAIL busy cyc=%0d byte=%02h got=%b required=%b", cyc, s.b, bus.busy, s.busy);
      end
   endtask

   task automatic chk_zero(input string name);
      logic [35:0] o;
      o = {bus.cmd, bus.tile_i, bus.tile_j, bus.op_code, bus.data_in, bus.offset,
           bus.valid, bus.start_pulse, bus.rd_req, bus.frame_err, bus.busy};
      n_cmp++;
      if (o !== 36'd0) begin
         n_bad++;
         $display("FAIL %s outputs got=%09h required=000000000", name, o);
      end else begin
         $display("txn %s outputs all zero ok", name);
      end
   endtask

   // Strobe monitor / scoreboard.
   always @(negedge clk) begin : mon
      logic [3:0] s;
      ev_t        got;
      exp_t       e;
      logic       ok;
      if (rst_n === 1'b1) begin
         s = {bus.valid, bus.start_pulse, bus.rd_req, bus.frame_err};
         if (s != 4'd0) begin
            case (s)
               4'b1000: got = EV_VALID;
               4'b0100: got = EV_START;
               4'b0010: got = EV_RD;
               4'b0001: got = EV_ERR;
               default: got = EV_NONE;
            endcase
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL strobe cyc=%0d got strobes=%b required none", cyc, s);
            end else begin
               e  = exp_q.pop_front();
               ok = (got == e.ev) && (cyc >= e.lo) && (cyc <= e.hi);
               case (e.ev)
                  EV_VALID: ok = ok && (bus.cmd == 8'h01) && (bus.data_in == e.d) && (bus.offset == e.off)
                                 && (bus.tile_i == e.ti) && (bus.tile_j == e.tj);
                  EV_START: ok = ok && (bus.cmd == 8'h02) && (bus.op_code == e.op)
                                 && (bus.tile_i == e.ti) && (bus.tile_j == e.tj);
                  EV_RD:    ok = ok && (bus.cmd == 8'h03) && (bus.tile_i == e.ti) && (bus.tile_j == e.tj);
                  default:  ok = ok;
               endcase
               if (!ok) begin
                  n_bad++;
                  $display("FAIL strobe cyc=%0d got ev=%0d cmd=%02h d=%02h off=%0d ti=%0d tj=%0d op=%0d required ev=%0d cyc=%0d..%0d d=%02h off=%0d ti=%0d tj=%0d op=%0d",
                           cyc, got, bus.cmd, bus.data_in, bus.offset, bus.tile_i, bus.tile_j, bus.op_code,
                           e.ev, e.lo, e.hi, e.d, e.off, e.ti, e.tj, e.op);
               end else begin
                  $display("txn cyc=%0d ev=%0d cmd=%02h d=%02h off=%0d ti=%0d tj=%0d op=%0d ok",
                           cyc, got, bus.cmd, bus.data_in, bus.offset, bus.tile_i, bus.tile_j, bus.op_code);
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.cs_n     = 1'b1;
      bus.rx_byte  = 8'h00;
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_zero("post_reset");

      tbl.push_back(sx(0, 1, 8'h00, 0));
      // WRITE of three bytes to tile (3,2)
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(sx(1, 0, 8'h1A, 1)); tbl.push_back(sx(1, 0, 8'h03, 1));
      tbl.push_back(sval(8'hAA, 0, 3, 2, 1)); tbl.push_back(sval(8'hBB, 1, 3, 2, 1));
      tbl.push_back(sval(8'hCC, 2, 3, 2, 0)); tbl.push_back(sx(0, 1, 8'h00, 0));
      // START op 5 on tile (1,1)
      tbl.push_back(sx(1, 0, 8'h02, 1)); tbl.push_back(sx(1, 0, 8'h09, 1));
      tbl.push_back(sst(8'h05, 5, 1, 1)); tbl.push_back(sx(0, 1, 8'h00, 0));
      // READ, then unknown command drained until cs_n high
      tbl.push_back(sx(1, 0, 8'h03, 1)); tbl.push_back(srd(8'h00, 0, 0)); tbl.push_back(sx(0, 1, 8'h00, 0));
      tbl.push_back(serr(1, 0, 8'h7F, 1)); tbl.push_back(sx(1, 0, 8'h01, 1));
      tbl.push_back(sx(1, 0, 8'h02, 1)); tbl.push_back(sx(0, 1, 8'h00, 0));
      // WRITE length 0 and length 65
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(sx(1, 0, 8'h00, 1)); tbl.push_back(serr(1, 0, 8'h00, 1));
      tbl.push_back(sx(1, 0, 8'h55, 1)); tbl.push_back(sx(0, 1, 8'h00, 0));
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(sx(1, 0, 8'h12, 1)); tbl.push_back(serr(1, 0, 8'h41, 1));
      tbl.push_back(sx(0, 1, 8'h00, 0));
      // tile byte with reserved bits set
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(serr(1, 0, 8'hC0, 1)); tbl.push_back(sx(0, 1, 8'h00, 0));
      // WRITE N=4 aborted after two bytes, then a normal START
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(sx(1, 0, 8'h3F, 1)); tbl.push_back(sx(1, 0, 8'h04, 1));
      tbl.push_back(sval(8'h11, 0, 7, 7, 1)); tbl.push_back(sval(8'h22, 1, 7, 7, 1));
      tbl.push_back(serr(0, 1, 8'h00, 0));
      tbl.push_back(sx(1, 0, 8'h02, 1)); tbl.push_back(sx(1, 0, 8'h24, 1));
      tbl.push_back(sst(8'h07, 7, 4, 4)); tbl.push_back(sx(0, 1, 8'h00, 0));
      // byte coincident with cs_n rising is dropped; byte in IDLE with cs_n high ignored
      tbl.push_back(sx(1, 0, 8'h01, 1)); tbl.push_back(sx(1, 0, 8'h1A, 1)); tbl.push_back(sx(1, 0, 8'h02, 1));
      tbl.push_back(sval(8'h5A, 0, 3, 2, 1)); tbl.push_back(serr(1, 1, 8'h6B, 0));
      tbl.push_back(sx(1, 1, 8'h01, 0)); tbl.push_back(sx(1, 0, 8'h03, 1));
      tbl.push_back(srd(8'h2D, 5, 5)); tbl.push_back(sx(0, 1, 8'h00, 0));

      foreach (tbl[k]) apply(tbl[k]);

      // Maximum-length WRITE: 64 bytes, offsets 0..63
      apply(sx(1, 0, 8'h01, 1)); apply(sx(1, 0, 8'h2C, 1)); apply(sx(1, 0, 8'h40, 1));
      for (int i = 0; i < 64; i++) apply(sval(8'(i) ^ 8'hA5, 6'(i), 5, 4, (i != 63)));
      apply(sx(0, 1, 8'h00, 0));

      // A stall shorter than the timeout is tolerated
      apply(sx(1, 0, 8'h02, 1)); apply(sx(1, 0, 8'h09, 1));
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (3000) @(negedge clk);
      apply(sst(8'h06, 6, 1, 1)); apply(sx(0, 1, 8'h00, 0));

      // Header stall beyond the timeout
      apply(sx(1, 0, 8'h01, 1));
      c = cyc;
      push_exp(EV_ERR, 8'h00, 6'd0, 3'd0, 3'd0, 3'd0, c + TIMEOUT_CYC - 8, c + TIMEOUT_CYC + 8);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (TIMEOUT_CYC + 100) @(negedge clk);
      apply(sx(0, 0, 8'h00, 1)); apply(sx(0, 1, 8'h00, 0));

      // Reset in the middle of a payload
      apply(sx(1, 0, 8'h01, 1)); apply(sx(1, 0, 8'h1A, 1)); apply(sx(1, 0, 8'h05, 1));
      apply(sval(8'hAA, 0, 3, 2, 1)); apply(sval(8'hBB, 1, 3, 2, 1));
      @(negedge clk);
      bus.rx_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_zero("reset_mid_payload");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply(sx(1, 0, 8'h03, 1)); apply(srd(8'h12, 2, 2)); apply(sx(0, 1, 8'h00, 0));

      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_strobes got=%0d outstanding required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
